// File: rtl/decode_fwd.sv
// RV32I decode stage: one registered output slot, valid/ready on both sides,
// operand forwarding from NUM_BYP result ports and load-use back-pressure.
module decode_fwd #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_BYP = 2,
  parameter int unsigned EX_W    = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_pc,
  input  logic [31:0]             in_instr,
  input  logic [EX_W-1:0]         in_ex,
  input  logic                    in_ex_valid,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [NUM_BYP-1:0]      byp_valid,
  input  logic [NUM_BYP-1:0]      byp_pend,
  input  logic [5*NUM_BYP-1:0]    byp_rd,
  input  logic [XLEN*NUM_BYP-1:0] byp_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_instr,
  output logic [4:0]              out_opcode,
  output logic [2:0]              out_funct,
  output logic                    out_variant,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_offset,
  output logic [4:0]              out_rd,
  output logic                    out_nop,
  output logic [EX_W-1:0]         out_ex,
  output logic                    out_ex_valid,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam logic [EX_W-1:0] EX_ILLEGAL_INSTR = EX_W'(2);
  localparam logic [2:0]      F3_CSRRW         = 3'b001;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     instr;
    logic [4:0]      opcode;
    logic [2:0]      funct;
    logic            variant;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] offset;
    logic [4:0]      rd;
    logic            nop;
    logic [EX_W-1:0] ex;
    logic            ex_valid;
  } dec_t;

  dec_t             dec_d, dec_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] stall_q;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] src1, src2;
  logic            pend1, pend2, use1, use2, illegal;
  logic            hazard, xfer, stall_inc;

  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'd0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  // Operand source: scanning high-to-low lets the lowest matching slot win.
  always_comb begin
    src1  = rs1_data;
    src2  = rs2_data;
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = int'(NUM_BYP) - 1; i >= 0; i--) begin
      if (byp_valid[i] && (byp_rd[5*i +: 5] == rs1_addr)) begin
        src1  = byp_data[XLEN*i +: XLEN];
        pend1 = byp_pend[i];
      end
      if (byp_valid[i] && (byp_rd[5*i +: 5] == rs2_addr)) begin
        src2  = byp_data[XLEN*i +: XLEN];
        pend2 = byp_pend[i];
      end
    end
    if (rs1_addr == 5'd0) begin
      src1  = '0;
      pend1 = 1'b0;
    end
    if (rs2_addr == 5'd0) begin
      src2  = '0;
      pend2 = 1'b0;
    end
  end

  // Field decode; exceptions zero the operands and suppress source usage.
  always_comb begin
    dec_d         = '0;
    use1          = 1'b0;
    use2          = 1'b0;
    illegal       = 1'b0;
    dec_d.pc      = in_pc;
    dec_d.instr   = in_instr;
    dec_d.opcode  = in_instr[6:2];
    dec_d.funct   = in_instr[14:12];
    dec_d.variant = in_instr[30];
    dec_d.rd      = in_instr[11:7];
    unique case (in_instr[6:2])
      OPC_OP_IMM: begin
        dec_d.op2 = imm_i;
        if (in_instr[31:12] == 20'd0) dec_d.nop = 1'b1;
        else                          use1      = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: dec_d.op2 = imm_u;
      OPC_OP: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OPC_JAL: dec_d.op2 = imm_j;
      OPC_JALR: begin
        if (in_instr[14:12] == 3'd0) begin
          use1      = 1'b1;
          dec_d.op2 = imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        use1         = 1'b1;
        use2         = 1'b1;
        dec_d.offset = imm_b;
      end
      OPC_LOAD: begin
        use1      = 1'b1;
        dec_d.op2 = imm_i;
      end
      OPC_STORE: begin
        use1         = 1'b1;
        use2         = 1'b1;
        dec_d.offset = imm_s;
      end
      OPC_FENCE: dec_d.nop = 1'b1;
      OPC_SYSTEM: begin
        if (in_instr[14:12] == F3_CSRRW) use1    = 1'b1;
        else                             illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
    if (use1) dec_d.op1 = src1;
    if (use2) dec_d.op2 = src2;

    if (in_ex_valid || illegal) begin
      use1           = 1'b0;
      use2           = 1'b0;
      dec_d.op1      = '0;
      dec_d.op2      = '0;
      dec_d.offset   = '0;
      dec_d.nop      = 1'b0;
      dec_d.ex_valid = 1'b1;
      dec_d.ex       = in_ex_valid ? in_ex : EX_ILLEGAL_INSTR;
    end
  end

  assign hazard    = (use1 && pend1) || (use2 && pend2);
  assign in_ready  = !flush && !hazard && (!valid_q || out_ready);
  assign xfer      = in_valid && in_ready;
  assign valid_d   = xfer || (valid_q && !flush && !out_ready);
  assign stall_inc = in_valid && hazard && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (xfer) dec_q <= dec_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = dec_q.pc;
  assign out_instr    = dec_q.instr;
  assign out_opcode   = dec_q.opcode;
  assign out_funct    = dec_q.funct;
  assign out_variant  = dec_q.variant;
  assign out_op1      = dec_q.op1;
  assign out_op2      = dec_q.op2;
  assign out_offset   = dec_q.offset;
  assign out_rd       = dec_q.rd;
  assign out_nop      = dec_q.nop;
  assign out_ex       = dec_q.ex;
  assign out_ex_valid = dec_q.ex_valid;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_fwd.sv
// Bench for decode_fwd: directed scenarios plus randomized traffic, checked
// by a queue scoreboard fed from a behavioural decode/forwarding model.
module tb_decode_fwd;

  localparam int unsigned NB = 2;
  localparam logic [3:0] EX_ILL = 4'd2;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready, in_ex_valid, out_ready;
  logic [31:0] in_pc, in_instr, rs1_data, rs2_data;
  logic [3:0]  in_ex;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [NB-1:0]    byp_valid, byp_pend;
  logic [5*NB-1:0]  byp_rd;
  logic [32*NB-1:0] byp_data;
  logic        out_valid, out_variant, out_nop, out_ex_valid;
  logic [31:0] out_pc, out_instr, out_op1, out_op2, out_offset;
  logic [4:0]  out_opcode, out_rd;
  logic [2:0]  out_funct;
  logic [3:0]  out_ex;
  logic [15:0] stall_cnt;

  logic        bv [NB];
  logic        bp [NB];
  logic [4:0]  brd [NB];
  logic [31:0] bd [NB];

  typedef struct {
    logic [31:0] pc, instr, op1, op2, off;
    logic        nop;
    logic [3:0]  ex;
    logic        exv;
    logic        hz;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_stall = 16'd0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      byp_valid[i]       = bv[i];
      byp_pend[i]        = bp[i];
      byp_rd[5*i +: 5]   = brd[i];
      byp_data[32*i +: 32] = bd[i];
    end
  end

  decode_fwd #(.XLEN(32), .NUM_BYP(NB), .EX_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .in_ex(in_ex), .in_ex_valid(in_ex_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .byp_valid(byp_valid), .byp_pend(byp_pend), .byp_rd(byp_rd), .byp_data(byp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_variant(out_variant),
    .out_op1(out_op1), .out_op2(out_op2), .out_offset(out_offset), .out_rd(out_rd),
    .out_nop(out_nop), .out_ex(out_ex), .out_ex_valid(out_ex_valid), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Value register r reads as, after forwarding from the youngest matching slot.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    for (int i = 0; i < NB; i++) if (bv[i] && brd[i] == r) return bd[i];
    return rf;
  endfunction

  function automatic logic waits(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    for (int i = 0; i < NB; i++) if (bv[i] && brd[i] == r) return bp[i];
    return 1'b0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic signed [31:0] s;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [4:0] r1, r2;
    logic u1, u2, ill;
    s  = signed'(in_instr);
    r1 = in_instr[19:15];
    r2 = in_instr[24:20];
    imm_i = 32'(s >>> 20);
    imm_s = 32'((s >>> 25) <<< 5) | 32'(in_instr[11:7]);
    imm_b = 32'((s >>> 31) <<< 12) | (32'(in_instr[7]) << 11) | (32'(in_instr[30:25]) << 5)
          | (32'(in_instr[11:8]) << 1);
    imm_u = in_instr & 32'hFFFF_F000;
    imm_j = 32'((s >>> 31) <<< 20) | (32'(in_instr[19:12]) << 12) | (32'(in_instr[20]) << 11)
          | (32'(in_instr[30:21]) << 1);
    e = '{pc: in_pc, instr: in_instr, op1: 32'd0, op2: 32'd0, off: 32'd0,
          nop: 1'b0, ex: 4'd0, exv: 1'b0, hz: 1'b0};
    u1 = 1'b0; u2 = 1'b0; ill = (in_instr[1:0] != 2'b11);
    case (in_instr[6:2])
      5'b00100: begin e.op2 = imm_i; if (in_instr[31:12] == 20'd0) e.nop = 1'b1; else u1 = 1'b1; end
      5'b01101, 5'b00101: e.op2 = imm_u;
      5'b01100: begin u1 = 1'b1; u2 = 1'b1; end
      5'b11011: e.op2 = imm_j;
      5'b11001: if (in_instr[14:12] == 3'd0) begin u1 = 1'b1; e.op2 = imm_i; end else ill = 1'b1;
      5'b11000: begin u1 = 1'b1; u2 = 1'b1; e.off = imm_b; end
      5'b00000: begin u1 = 1'b1; e.op2 = imm_i; end
      5'b01000: begin u1 = 1'b1; u2 = 1'b1; e.off = imm_s; end
      5'b00011: e.nop = 1'b1;
      5'b11100: if (in_instr[14:12] == 3'b001) u1 = 1'b1; else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    if (u1) e.op1 = fwd(r1, rs1_data);
    if (u2) e.op2 = fwd(r2, rs2_data);
    e.hz = (u1 && waits(r1)) || (u2 && waits(r2));
    if (in_ex_valid || ill) begin
      e.op1 = 32'd0; e.op2 = 32'd0; e.off = 32'd0; e.nop = 1'b0; e.hz = 1'b0;
      e.exv = 1'b1;
      e.ex  = in_ex_valid ? in_ex : EX_ILL;
    end
    return e;
  endfunction

  // One cycle: inputs already driven; check combinational outputs, then commit model state.
  task automatic step();
    exp_t e;
    logic exp_ready;
    #3;
    e = model();
    exp_ready = !flush && !e.hz && (q.size() == 0 || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("rs1_addr", 32'(rs1_addr), 32'(in_instr[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(in_instr[24:20]));
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    @(posedge clk);
    if (reset) begin
      q.delete();
      exp_stall = 16'd0;
    end else begin
      if (in_valid && exp_ready) q.push_back(e);
      if (in_valid && e.hz && !flush && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    end
    #1;
  endtask

  // Monitor: compare the held output against the scoreboard head; pop when consumed or flushed.
  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
        chk("out_opcode", 32'(out_opcode), 32'(q[0].instr[6:2]));
        chk("out_funct", 32'(out_funct), 32'(q[0].instr[14:12]));
        chk("out_variant", 32'(out_variant), 32'(q[0].instr[30]));
        chk("out_rd", 32'(out_rd), 32'(q[0].instr[11:7]));
        chk("out_op1", out_op1, q[0].op1);
        chk("out_op2", out_op2, q[0].op2);
        chk("out_offset", out_offset, q[0].off);
        chk("out_nop", 32'(out_nop), 32'(q[0].nop));
        chk("out_ex", 32'(out_ex), 32'(q[0].ex));
        chk("out_ex_valid", 32'(out_ex_valid), 32'(q[0].exv));
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  task automatic idle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 32'h0000_1000; in_instr = 32'h0000_0013; in_ex = 4'd0; in_ex_valid = 1'b0;
    rs1_data = 32'd0; rs2_data = 32'd0;
    for (int i = 0; i < NB; i++) begin bv[i] = 1'b0; bp[i] = 1'b0; brd[i] = 5'd0; bd[i] = 32'd0; end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    w[1:0] = 2'b11;
    w[19:15] = 5'($urandom_range(7));
    w[24:20] = 5'($urandom_range(7));
    case ($urandom_range(11))
      0: w[6:2] = 5'b00100;
      1: w[6:2] = 5'b01101;
      2: w[6:2] = 5'b00101;
      3: w[6:2] = 5'b01100;
      4: w[6:2] = 5'b11011;
      5: begin w[6:2] = 5'b11001; if ($urandom_range(3) != 0) w[14:12] = 3'd0; end
      6: w[6:2] = 5'b11000;
      7: w[6:2] = 5'b00000;
      8: w[6:2] = 5'b01000;
      9: w[6:2] = 5'b00011;
      10: begin w[6:2] = 5'b11100; if ($urandom_range(1) != 0) w[14:12] = 3'b001; end
      default: begin w[6:2] = 5'b00100; w[31:12] = 20'd0; end
    endcase
    if ($urandom_range(15) == 0) w = $urandom;
    return w;
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_op1", out_op1, 32'd0);
    chk("rst_out_offset", out_offset, 32'd0);
    chk("rst_out_nop", 32'(out_nop), 32'd0);
    chk("rst_out_ex_valid", 32'(out_ex_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back ADDI x1,x0,5 ; ADD x3,x1,x2
    in_valid = 1'b1; in_instr = 32'h0050_0093; step();
    chk("addi_op2", out_op2, 32'd5);
    in_instr = 32'h0020_81B3; in_pc = 32'h0000_1004; rs1_data = 32'h11; rs2_data = 32'd7; step();
    chk("add_op1", out_op1, 32'h11);
    chk("add_op2", out_op2, 32'd7);

    // Both slots match x1: slot 0 wins
    bv[0] = 1'b1; bv[1] = 1'b1; brd[0] = 5'd1; brd[1] = 5'd1; bd[0] = 32'h55; bd[1] = 32'hAA;
    step();
    chk("prio_op1", out_op1, 32'h55);

    // Load-use hazard on x5 for three cycles
    idle(); reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0002_8333;
    bv[0] = 1'b1; brd[0] = 5'd5; bp[0] = 1'b1; bd[0] = 32'h1234;
    for (int k = 0; k < 3; k++) step();
    chk("lw_ready", 32'(in_ready), 32'd0);
    chk("lw_stall3", 32'(stall_cnt), 32'd3);
    bp[0] = 1'b0; step();
    chk("lw_op1", out_op1, 32'h1234);
    chk("lw_valid", 32'(out_valid), 32'd1);

    // Held BEQ x1,x2,-8 under back-pressure
    idle(); in_valid = 1'b1; in_instr = 32'hFE20_8CE3; step();
    out_ready = 1'b0; in_instr = 32'h0050_0093;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_offset", out_offset, 32'hFFFF_FFF8);
      chk("hold_instr", out_instr, 32'hFE20_8CE3);
    end
    out_ready = 1'b1; step();

    // Illegal word and upstream exception with a matching pending slot
    idle(); in_valid = 1'b1; in_instr = 32'h0000_0000; step();
    chk("ill_exv", 32'(out_ex_valid), 32'd1);
    chk("ill_ex", 32'(out_ex), 32'(EX_ILL));
    in_instr = 32'h0002_8333; in_ex_valid = 1'b1; in_ex = 4'd1;
    bv[0] = 1'b1; brd[0] = 5'd5; bp[0] = 1'b1; step();
    chk("exin_ex", 32'(out_ex), 32'd1);
    chk("exin_instr", out_instr, 32'h0002_8333);

    // Flush while holding and offered a new instruction
    idle(); in_valid = 1'b1; in_instr = 32'h0050_0093; step();
    flush = 1'b1; out_ready = 1'b0; step();
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall
    idle(); in_valid = 1'b1; in_instr = 32'h0002_8333;
    bv[0] = 1'b1; brd[0] = 5'd5; bp[0] = 1'b1;
    step(); step();
    chk("mid_stall2", 32'(stall_cnt), 32'(exp_stall));
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(299) == 0);
      flush       = ($urandom_range(29) == 0);
      in_valid    = ($urandom_range(4) != 0);
      out_ready   = ($urandom_range(3) != 0);
      in_instr    = rnd_instr();
      in_pc       = 32'($urandom) & 32'hFFFF_FFFC;
      in_ex_valid = ($urandom_range(19) == 0);
      in_ex       = 4'($urandom);
      rs1_data    = $urandom;
      rs2_data    = $urandom;
      for (int i = 0; i < NB; i++) begin
        bv[i]  = 1'($urandom_range(1));
        brd[i] = 5'($urandom_range(7));
        bd[i]  = $urandom;
        bp[i]  = ($urandom_range(5) == 0);
      end
      step();
    end

    idle();
    for (int k = 0; k < 3; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
